spectrum_band_aggregator: RTL and testbench
===========================================

# spectrum_band_aggregator

Consumes the magnitude stream from the FFT core and reduces the 256 positive-frequency bins to NUM_BANDS band levels (max per band) for the display/LED driver. Each level is committed frame-atomically when the FFT done pulse arrives, with optional peak-hold and decay. Sits directly downstream of the FFT top and upstream of the display interface, which polls levels through a registered read port.

## Interface
- DATA_WIDTH, 24, magnitude width
- BIN_ADDR_WIDTH, 9, FFT bin address width (512 points)
- NUM_BANDS, 16, band count; power of two, 2..128
- DECAY_SHIFT, 4, peak decay per frame = peak >> DECAY_SHIFT
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_mag_addr  in  BIN_ADDR_WIDTH  bin index of current magnitude
- i_mag_data  in  DATA_WIDTH  unsigned magnitude
- i_mag_valid  in  1  magnitude strobe, one bin per cycle max
- i_fft_done  in  1  single-cycle end-of-frame pulse
- i_rd_band  in  $clog2(NUM_BANDS)  band to read
- o_rd_level  out  DATA_WIDTH  committed level of i_rd_band, 1-cycle latency
- o_rd_peak  out  DATA_WIDTH  peak-hold of i_rd_band, 1-cycle latency
- o_frame_valid  out  1  one-cycle pulse: new frame committed
- o_frame_count  out  16  committed-frame counter, wraps 0xFFFF->0
- o_committing  out  1  high during COMMIT
- o_overrun  out  1  sticky: magnitude dropped during COMMIT

## Operation
- Band mapping: bins 1..255 used; band = i_mag_addr[7 : 8-log2(NUM_BANDS)]. Bin 0 (DC) and addr >= 256 (mirror) ignored.
- Working array work[NUM_BANDS]: on accepted valid, work[band] <= max(work[band], i_mag_data), unsigned compare.
- FSM states: IDLE, COLLECT, COMMIT.
  - IDLE -> COLLECT on any i_mag_valid; IDLE -> COMMIT on i_fft_done (commits current work, zeros if none).
  - COLLECT -> COMMIT on i_fft_done.
  - COMMIT: band counter k runs 0..NUM_BANDS-1, one band per cycle: level[k] <= work[k]; work[k] <= 0; peak update (see Configuration). After k = NUM_BANDS-1 -> IDLE, o_frame_valid pulses, o_frame_count increments.
- Simultaneous i_mag_valid and i_fft_done: the sample is merged into work before commit.
- i_mag_valid during COMMIT: sample dropped, o_overrun set; cleared only by reset.
- i_fft_done during COMMIT: ignored.
- Read port: o_rd_level/o_rd_peak registered from i_rd_band every cycle, independent of FSM. Reads during COMMIT may return a mix of old and new frame; display samples after o_frame_valid.

## Timing
- Reset: all outputs 0, work/level/peak arrays 0, FSM IDLE, k = 0. Reset mid-COMMIT aborts immediately; no partial o_frame_valid.
- i_fft_done at cycle t: o_committing high t+1..t+NUM_BANDS; o_frame_valid high at t+NUM_BANDS+1 (o_committing low).
- Read latency: i_rd_band at edge n -> data valid after edge n+1.
- Sample accepted at edge n is visible in work at n+1.

## Configuration
- SPECTRUM_PEAK_HOLD_EN defined: peak[NUM_BANDS] registers; on commit of band k, peak[k] <= (work[k] >= peak[k] - (peak[k] >> DECAY_SHIFT)) ? work[k] : peak[k] - (peak[k] >> DECAY_SHIFT); o_rd_peak returns peak[i_rd_band].
- Not defined: no peak registers; o_rd_peak equals o_rd_level (same cycle, same value).

## Test plan
- Reset then frame with bin 17 = 0x000100, bin 20 = 0x000300, others 0, then done -> band 1 level 0x000300, other bands 0, o_frame_valid at done+17, o_frame_count = 1.
- Bin 0 = 0xFFFFFF and bin 300 = 0xFFFFFF only, done -> all levels 0.
- Last bin valid in same cycle as i_fft_done (bin 255 = 0x00ABCD) -> band 15 level 0x00ABCD.
- i_mag_valid during COMMIT -> o_overrun = 1 and stays 1; sample absent from next frame; second i_fft_done during COMMIT produces no extra o_frame_valid.
- With SPECTRUM_PEAK_HOLD_EN: frame band 0 = 0x001000, then two empty frames -> peak 0x001000, 0x000F00, 0x000E10; level 0 after the empty frames. Without macro: o_rd_peak == o_rd_level throughout.
- Assert rst_n low mid-COMMIT -> all outputs 0 within the same cycle, no o_frame_valid; subsequent frame commits normally with o_frame_count = 1.

Source files
------------

// File: rtl/spectrum_band_aggregator.sv
// ---------------------------------------------------------------------------
// spectrum_band_aggregator
//
// Reduces the 256 positive-frequency FFT magnitude bins to NUM_BANDS band
// levels (maximum magnitude per band). Bins are folded into a working array
// while the frame streams in. On the FFT done pulse the working array is
// committed into the level array one band per cycle, and the working array
// is cleared behind it. The display side polls levels through a registered
// read port.
//
// Optional feature (compile-time macro):
//   SPECTRUM_PEAK_HOLD_EN - adds per-band peak-hold registers that decay by
//                           peak >> DECAY_SHIFT on every committed frame.
//                           When undefined, o_rd_peak mirrors o_rd_level.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   i_mag_addr     FFT bin index of the current magnitude
//   i_mag_data     unsigned magnitude
//   i_mag_valid    magnitude strobe (at most one bin per cycle)
//   i_fft_done     single-cycle end-of-frame pulse
//   i_rd_band      band index to read
//   o_rd_level     committed level of i_rd_band (1-cycle latency)
//   o_rd_peak      peak-hold of i_rd_band (1-cycle latency)
//   o_frame_valid  one-cycle pulse when a frame has been fully committed
//   o_frame_count  committed-frame counter, wraps
//   o_committing   high while the commit sweep runs
//   o_overrun      sticky flag: a magnitude arrived during a commit sweep
// ---------------------------------------------------------------------------
module spectrum_band_aggregator #(
  parameter int  DATA_WIDTH     = 24,
  parameter int  BIN_ADDR_WIDTH = 9,
  parameter int  NUM_BANDS      = 16,
  parameter int  DECAY_SHIFT    = 4,
  localparam int BAND_W         = $clog2(NUM_BANDS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [BIN_ADDR_WIDTH-1:0] i_mag_addr,
  input  logic [DATA_WIDTH-1:0]     i_mag_data,
  input  logic                      i_mag_valid,
  input  logic                      i_fft_done,
  input  logic [BAND_W-1:0]         i_rd_band,
  output logic [DATA_WIDTH-1:0]     o_rd_level,
  output logic [DATA_WIDTH-1:0]     o_rd_peak,
  output logic                      o_frame_valid,
  output logic [15:0]               o_frame_count,
  output logic                      o_committing,
  output logic                      o_overrun
);

  localparam logic [1:0]        S_IDLE    = 2'd0;
  localparam logic [1:0]        S_COLLECT = 2'd1;
  localparam logic [1:0]        S_COMMIT  = 2'd2;
  localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NUM_BANDS - 1);

  logic [1:0]            r_state;
  logic [BAND_W-1:0]     r_k;
  logic [DATA_WIDTH-1:0] r_work  [NUM_BANDS];
  logic [DATA_WIDTH-1:0] r_level [NUM_BANDS];
  logic                  r_frame_valid;
  logic [15:0]           r_frame_count;
  logic                  r_overrun;
  logic [DATA_WIDTH-1:0] r_rd_level;

  logic                  w_commit;
  logic                  w_bin_ok;
  logic                  w_accept;
  logic [BAND_W-1:0]     w_band;

  assign w_commit = (r_state == S_COMMIT);
  // Only bins 1..255 carry information: bin 0 is DC, 256 and up mirror.
  assign w_bin_ok = ~|(i_mag_addr >> 8) & (i_mag_addr[7:0] != 8'd0);
  // Samples are dropped during the sweep so the committed frame is atomic.
  assign w_accept = i_mag_valid & w_bin_ok & ~w_commit;
  assign w_band   = i_mag_addr[7 -: BAND_W];

  // Control: frame state, commit band counter, frame flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_k           <= '0;
      r_frame_valid <= 1'b0;
      r_frame_count <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      if (w_commit && i_mag_valid) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (i_fft_done)       r_state <= S_COMMIT;
          else if (i_mag_valid) r_state <= S_COLLECT;
        end
        S_COLLECT: begin
          if (i_fft_done) r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          // A done pulse arriving here is ignored on purpose.
          if (r_k == LAST_BAND) begin
            r_state       <= S_IDLE;
            r_k           <= '0;
            r_frame_valid <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
          end else begin
            r_k <= r_k + BAND_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Working/level arrays: max-accumulate while collecting, sweep on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        r_work[i]  <= '0;
        r_level[i] <= '0;
      end
    end else if (w_commit) begin
      r_level[r_k] <= r_work[r_k];
      r_work[r_k]  <= '0;
    end else if (w_accept && (i_mag_data > r_work[w_band])) begin
      r_work[w_band] <= i_mag_data;
    end
  end

  // Registered read port, independent of the frame state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_level <= '0;
    else        r_rd_level <= r_level[i_rd_band];
  end

`ifdef SPECTRUM_PEAK_HOLD_EN
  logic [DATA_WIDTH-1:0] r_peak [NUM_BANDS];
  logic [DATA_WIDTH-1:0] r_rd_peak;

  // New peak: the fresh level if it beats the decayed peak, else the decay.
  function automatic logic [DATA_WIDTH-1:0] peak_next(
    input logic [DATA_WIDTH-1:0] level,
    input logic [DATA_WIDTH-1:0] peak
  );
    logic [DATA_WIDTH-1:0] decayed;
    decayed = peak - (peak >> DECAY_SHIFT);
    return (level >= decayed) ? level : decayed;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANDS; i++) r_peak[i] <= '0;
    end else if (w_commit) begin
      r_peak[r_k] <= peak_next(r_work[r_k], r_peak[r_k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_peak <= '0;
    else        r_rd_peak <= r_peak[i_rd_band];
  end

  assign o_rd_peak = r_rd_peak;
`else
  assign o_rd_peak = r_rd_level;
`endif

  assign o_rd_level    = r_rd_level;
  assign o_frame_valid = r_frame_valid;
  assign o_frame_count = r_frame_count;
  assign o_committing  = w_commit;
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_spectrum_band_aggregator.sv
module tb_spectrum_band_aggregator;
  localparam int DW = 24;
  localparam int AW = 9;
  localparam int NB = 16;
  localparam int DS = 4;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] i_mag_addr;
  logic [DW-1:0] i_mag_data;
  logic          i_mag_valid;
  logic          i_fft_done;
  logic [BW-1:0] i_rd_band;
  logic [DW-1:0] o_rd_level;
  logic [DW-1:0] o_rd_peak;
  logic          o_frame_valid;
  logic [15:0]   o_frame_count;
  logic          o_committing;
  logic          o_overrun;

  spectrum_band_aggregator #(
    .DATA_WIDTH(DW), .BIN_ADDR_WIDTH(AW), .NUM_BANDS(NB), .DECAY_SHIFT(DS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mag_addr(i_mag_addr), .i_mag_data(i_mag_data),
    .i_mag_valid(i_mag_valid), .i_fft_done(i_fft_done),
    .i_rd_band(i_rd_band),
    .o_rd_level(o_rd_level), .o_rd_peak(o_rd_peak),
    .o_frame_valid(o_frame_valid), .o_frame_count(o_frame_count),
    .o_committing(o_committing), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: frame-level view. A done pulse snapshots the working
  // maxima into "next" arrays; the sweep then exposes band b once b bands
  // have been committed, and the frame becomes current after NB cycles.
  logic [DW-1:0] m_work   [NB];
  logic [DW-1:0] m_lv     [NB];
  logic [DW-1:0] m_pk     [NB];
  logic [DW-1:0] m_new_lv [NB];
  logic [DW-1:0] m_new_pk [NB];
  int            m_left;
  logic [15:0]   m_cnt;
  logic          m_ovr;
  logic          m_fv;
  logic [DW-1:0] e_rd_lv;
  logic [DW-1:0] e_rd_pk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_work[b] = '0; m_lv[b] = '0; m_pk[b] = '0; m_new_lv[b] = '0; m_new_pk[b] = '0;
    end
    m_left = 0; m_cnt = '0; m_ovr = 1'b0; m_fv = 1'b0; e_rd_lv = '0; e_rd_pk = '0;
  endtask

  function automatic logic [DW-1:0] vis_lv(int b);
    return (m_left > 0 && b < NB - m_left) ? m_new_lv[b] : m_lv[b];
  endfunction

  function automatic logic [DW-1:0] vis_pk(int b);
    return (m_left > 0 && b < NB - m_left) ? m_new_pk[b] : m_pk[b];
  endfunction

  task automatic model_step();
    int b;
    int decayed;
    e_rd_lv = vis_lv(int'(i_rd_band));
`ifdef SPECTRUM_PEAK_HOLD_EN
    e_rd_pk = vis_pk(int'(i_rd_band));
`else
    e_rd_pk = e_rd_lv;
`endif
    m_fv = 1'b0;
    if (m_left > 0) begin
      if (i_mag_valid) m_ovr = 1'b1;
      m_left--;
      if (m_left == 0) begin
        for (int k = 0; k < NB; k++) begin m_lv[k] = m_new_lv[k]; m_pk[k] = m_new_pk[k]; end
        m_cnt++;
        m_fv = 1'b1;
      end
    end else begin
      if (i_mag_valid && int'(i_mag_addr) >= 1 && int'(i_mag_addr) <= 255) begin
        b = int'(i_mag_addr) * NB / 256;
        if (i_mag_data > m_work[b]) m_work[b] = i_mag_data;
      end
      if (i_fft_done) begin
        for (int k = 0; k < NB; k++) begin
          decayed = int'(m_pk[k]) - int'(m_pk[k]) / (1 << DS);
          m_new_lv[k] = m_work[k];
          m_new_pk[k] = (int'(m_work[k]) >= decayed) ? m_work[k] : DW'(decayed);
          m_work[k] = '0;
        end
        m_left = NB;
      end
    end
  endtask

  task automatic compare();
    check("rd_level",    o_rd_level,    e_rd_lv);
    check("rd_peak",     o_rd_peak,     e_rd_pk);
    check("frame_valid", o_frame_valid, m_fv);
    check("frame_count", o_frame_count, m_cnt);
    check("committing",  o_committing,  (m_left > 0));
    check("overrun",     o_overrun,     m_ovr);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic send_bin(input int addr, input int data);
    i_mag_valid = 1'b1; i_mag_addr = AW'(addr); i_mag_data = DW'(data);
    cycle();
    i_mag_valid = 1'b0;
  endtask

  // Raises done (with whatever valid is already set), then waits for the frame.
  task automatic done_and_wait(output int lat);
    i_fft_done = 1'b1;
    cycle();
    lat = 1;
    i_fft_done = 1'b0; i_mag_valid = 1'b0;
    while (!o_frame_valid && lat < 40) begin cycle(); lat++; end
    check("frame_arrived", o_frame_valid, 1'b1);
  endtask

  task automatic read_band(input int b, output logic [DW-1:0] lv, output logic [DW-1:0] pk);
    i_rd_band = BW'(b);
    cycle();
    lv = o_rd_level; pk = o_rd_peak;
  endtask

  initial begin
    int lat;
    int guard;
    logic [DW-1:0] lv, pk;
    logic [15:0] cnt_before;

    rst_n = 1'b0; i_mag_addr = '0; i_mag_data = '0; i_mag_valid = 1'b0;
    i_fft_done = 1'b0; i_rd_band = '0;
    model_reset();
    repeat (3) cycle();
    check("rst_level", o_rd_level, 0);
    check("rst_count", o_frame_count, 0);
    check("rst_commit", o_committing, 0);
    rst_n = 1'b1;
    cycle();

    // Two bins in band 1; the larger one wins.
    send_bin(17, 'h000100);
    send_bin(20, 'h000300);
    done_and_wait(lat);
    check("fv_latency", lat, 17);
    check("count_first", o_frame_count, 1);
    check("model_band1", m_lv[1], 'h000300);
    read_band(1, lv, pk); check("band1_level", lv, 'h000300);
    read_band(0, lv, pk); check("band0_level", lv, 0);
    read_band(2, lv, pk); check("band2_level", lv, 0);

    // DC and mirror bins are ignored.
    send_bin(0, 'hFFFFFF);
    send_bin(300, 'hFFFFFF);
    done_and_wait(lat);
    for (int b = 0; b < NB; b++) begin
      read_band(b, lv, pk); check("ignored_bins", lv, 0);
    end

    // Last bin in the same cycle as done is merged.
    i_mag_valid = 1'b1; i_mag_addr = AW'(255); i_mag_data = DW'('h00ABCD);
    done_and_wait(lat);
    read_band(15, lv, pk); check("band15_merge", lv, 'h00ABCD);

    // Peak-hold with decay over two empty frames.
    send_bin(5, 'h001000);
    done_and_wait(lat);
    read_band(0, lv, pk); check("peak_lvl_f1", lv, 'h001000);
`ifdef SPECTRUM_PEAK_HOLD_EN
    check("peak_f1", pk, 'h001000);
`else
    check("peak_eq_f1", pk, lv);
`endif
    done_and_wait(lat);
    read_band(0, lv, pk); check("peak_lvl_f2", lv, 0);
`ifdef SPECTRUM_PEAK_HOLD_EN
    check("peak_f2", pk, 'h000F00);
`else
    check("peak_eq_f2", pk, lv);
`endif
    done_and_wait(lat);
    read_band(0, lv, pk); check("peak_lvl_f3", lv, 0);
`ifdef SPECTRUM_PEAK_HOLD_EN
    check("peak_f3", pk, 'h000E10);
`else
    check("peak_eq_f3", pk, lv);
`endif

    // Sample and second done during commit: dropped, overrun sticky.
    cnt_before = o_frame_count;
    i_fft_done = 1'b1; cycle(); i_fft_done = 1'b0;
    cycle(); cycle();
    send_bin(40, 'h000777);
    i_fft_done = 1'b1; cycle(); i_fft_done = 1'b0;
    check("overrun_set", o_overrun, 1);
    repeat (30) cycle();
    check("one_frame_only", o_frame_count, cnt_before + 16'd1);
    check("overrun_sticky", o_overrun, 1);
    done_and_wait(lat);
    read_band(2, lv, pk); check("dropped_absent", lv, 0);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      i_mag_valid = ($urandom_range(0, 9) < 6);
      i_mag_addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(256, 511))
                                                : AW'($urandom_range(0, 255));
      i_mag_data  = DW'($urandom);
      i_fft_done  = ($urandom_range(0, 39) == 0);
      i_rd_band   = BW'($urandom_range(0, NB - 1));
      cycle();
    end
    i_mag_valid = 1'b0; i_fft_done = 1'b0;
    guard = 0;
    while (o_committing && guard < 40) begin cycle(); guard++; end
    check("drain", o_committing, 0);
    repeat (2) cycle();

    // Reset in the middle of a commit sweep.
    send_bin(17, 'h000055);
    i_fft_done = 1'b1; cycle(); i_fft_done = 1'b0;
    repeat (5) cycle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_level", o_rd_level, 0);
    check("midrst_peak", o_rd_peak, 0);
    check("midrst_fv", o_frame_valid, 0);
    check("midrst_count", o_frame_count, 0);
    check("midrst_commit", o_committing, 0);
    check("midrst_ovr", o_overrun, 0);
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (20) cycle();
    send_bin(18, 'h000066);
    done_and_wait(lat);
    check("post_rst_count", o_frame_count, 1);
    read_band(1, lv, pk); check("post_rst_band1", lv, 'h000066);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
